// File: rtl/ucomb_loader.sv
// rtl/ucomb_loader.sv - serial configuration-chain loader for the universal combinational gate pin mapper
// Optional build macro UCOMB_LOADER_CHECK_EN enables the multi-bit wiring error check.
module ucomb_loader #(
  parameter int SETTLE = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic [15:0] req_func,
  output logic [1:0]  map_sel,
  output logic [15:0] map_func,
  output logic [3:0]  map_pin,
  input  logic [5:0]  map_wpin,
  output logic        cfg_data,
  output logic        cfg_en,
  output logic        cfg_latch,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_LATCH  = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_sel;
  logic [15:0] r_func;
  logic [3:0]  r_pin;
  logic [5:0]  r_shift;
  logic [3:0]  r_settle_cnt;
  logic [2:0]  r_bit_cnt;

  logic [3:0]  w_last_pin;
  logic        w_settle_done;

  always_comb begin
    w_last_pin = 4'd3;
    case (r_sel)
      2'd0:    w_last_pin = 4'd3;
      2'd1:    w_last_pin = 4'd5;
      2'd2:    w_last_pin = 4'd9;
      default: w_last_pin = 4'd5;
    endcase
  end

  assign w_settle_done = (r_state == ST_SETTLE) && (r_settle_cnt == SETTLE_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_sel        <= 2'd0;
      r_func       <= 16'd0;
      r_pin        <= 4'd0;
      r_shift      <= 6'd0;
      r_settle_cnt <= 4'd0;
      r_bit_cnt    <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_sel        <= req_sel;
            r_func       <= req_func;
            r_pin        <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_settle_done) begin
            r_shift   <= map_wpin;
            r_bit_cnt <= 3'd0;
            r_state   <= ST_SHIFT;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        ST_SHIFT: begin
          // MSB leaves first; the register is refilled by the next capture
          r_shift <= {r_shift[4:0], 1'b0};
          if (r_bit_cnt == 3'd5) begin
            if (r_pin == w_last_pin) begin
              r_state <= ST_LATCH;
            end else begin
              r_pin        <= r_pin + 4'd1;
              r_settle_cnt <= 4'd0;
              r_state      <= ST_SETTLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset forces the outputs low immediately, not only after the reset edge
  assign req_ready = !wb_rst_i && (r_state == ST_IDLE);
  assign busy      = !wb_rst_i && (r_state != ST_IDLE);
  assign cfg_en    = !wb_rst_i && (r_state == ST_SHIFT);
  assign cfg_data  = cfg_en && r_shift[5];
  assign cfg_latch = !wb_rst_i && (r_state == ST_LATCH);
  assign map_sel   = wb_rst_i ? 2'd0  : r_sel;
  assign map_func  = wb_rst_i ? 16'd0 : r_func;
  assign map_pin   = wb_rst_i ? 4'd0  : r_pin;

`ifdef UCOMB_LOADER_CHECK_EN
  logic r_err;
  logic w_multi;

  assign w_multi = |(map_wpin & (map_wpin - 6'd1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && req_valid) begin
      r_err <= 1'b0;
    end else if (w_settle_done && w_multi) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err && !wb_rst_i;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/ucomb_loader.md
UCOMB_LOADER -- requirements
Module: ucomb_loader

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the number of cycles map_pin is held before map_wpin is sampled; legal range 1..15.
REQ-002 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a load request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port req_sel, input, 2 bits: gate type (0 = u21, 1 = u31, 2 = u41, 3 = u22).
REQ-007 The block SHALL have port req_func, input, 16 bits: the gate function word.
REQ-008 The block SHALL have ports map_sel (output, 2 bits), map_func (output, 16 bits) and map_pin (output, 4 bits), which drive the downstream combinational pin mapper.
REQ-009 The block SHALL have port map_wpin, input, 6 bits: the one-hot wiring returned by the mapper.
REQ-010 The block SHALL have ports cfg_data (output, 1 bit) and cfg_en (output, 1 bit): the serial configuration chain bit and its shift strobe.
REQ-011 The block SHALL have port cfg_latch, output, 1 bit: a one-cycle pulse that commits the chain contents.
REQ-012 The block SHALL have ports busy (output, 1 bit: a load is in progress) and err (output, 1 bit: sticky wiring error flag).

Function
REQ-013 The handshake SHALL complete when req_valid and req_ready are both 1 on a rising edge; req_ready SHALL be 1 only in state IDLE.
REQ-014 On acceptance the block SHALL capture req_sel and req_func, SHALL drive them on map_sel and map_func until the next acceptance, and SHALL clear err.
REQ-015 The pin count N SHALL be 4 for sel 0, 6 for sel 1, 10 for sel 2 and 6 for sel 3.
REQ-016 The block SHALL implement exactly four states: IDLE, SETTLE, SHIFT and LATCH.
REQ-017 On acceptance the block SHALL go IDLE -> SETTLE with map_pin set to 0.
REQ-018 SETTLE SHALL last exactly SETTLE cycles with map_pin stable; on its last cycle map_wpin SHALL be captured into a 6-bit shift register and the state SHALL move to SHIFT.
REQ-019 SHIFT SHALL last exactly 6 cycles with cfg_en = 1, presenting the captured bits MSB first (bit 5 down to bit 0) on cfg_data.
REQ-020 After the 6th SHIFT cycle, if map_pin equals N-1 the block SHALL go to LATCH; otherwise map_pin SHALL increment by 1 and the block SHALL go to SETTLE.
REQ-021 LATCH SHALL last exactly 1 cycle with cfg_latch = 1 and SHALL then return to IDLE.
REQ-022 Outside SHIFT, cfg_en SHALL be 0 and cfg_data SHALL be 0; outside LATCH, cfg_latch SHALL be 0.
REQ-023 busy SHALL be 1 in SETTLE, SHIFT and LATCH, and 0 in IDLE.
REQ-024 Timing: with acceptance at cycle 0, there SHALL be N*6 cfg_en cycles and cfg_latch SHALL be high at cycle N*(SETTLE+6)+1, and req_ready SHALL be 1 again at cycle N*(SETTLE+6)+2.
REQ-025 While busy, req_valid SHALL be ignored; it SHALL NOT be queued.
REQ-026 A zero map_wpin (unconnected pin) SHALL be legal and SHALL shift out six 0s.

Reset
REQ-027 While wb_rst_i = 1 the block SHALL enter IDLE and SHALL hold req_ready = 1 after the reset cycle.
REQ-028 While wb_rst_i = 1, busy, cfg_en, cfg_data, cfg_latch and err SHALL be 0, map_pin SHALL be 0, and map_sel and map_func SHALL be 0.
REQ-029 A reset asserted mid-load SHALL abort the load immediately with no cfg_latch pulse, and the partial chain contents SHALL be left uncommitted.

Configuration
REQ-030 With macro UCOMB_LOADER_CHECK_EN defined, each captured map_wpin with more than one bit set SHALL set err on the following cycle, and err SHALL hold until the next acceptance or reset; the load SHALL continue unchanged.
REQ-031 With UCOMB_LOADER_CHECK_EN undefined, err SHALL be tied to 0 and no checking logic SHALL be built.

Verification
REQ-032 Scenario: SETTLE=1, mapper stub returns 6'b100000, sel=0 accepted at cycle 0 -> 24 cfg_en cycles with pattern 100000 repeated 4 times, and cfg_latch high at cycle 29.
REQ-033 Scenario: sel=2 with the same stub -> 60 cfg_en cycles, map_pin stepping 0..9, cfg_latch high at cycle 71, and req_ready back to 1 at cycle 72.
REQ-034 Scenario: stub returns 6'b000011 only when map_pin=2, macro defined -> err rises after the third capture and stays 1 through IDLE; the next acceptance clears it; with the macro undefined err stays 0.
REQ-035 Scenario: req_valid held at 1 across two requests -> the second is accepted exactly one cycle after the LATCH cycle, and no request is lost or duplicated.
REQ-036 Scenario: wb_rst_i pulsed at cycle 10 of a sel=1 load -> next cycle IDLE, cfg_en=0, no cfg_latch, map_pin=0 and req_ready=1.
